// File: rtl/fix2dec_ascii.sv
// fix2dec_ascii: converts a captured fixed-point value (INT_BITS integer bits,
// F = W-INT_BITS fraction bits) into an ASCII decimal string "I.DDDD...",
// streamed one byte per valid/ready beat. Fraction digits are produced by
// repeated multiply-by-10 of the fraction register.
//
// Optional feature macro: FIX2DEC_CRLF_EN appends CR LF after the last digit.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle request; captures value when idle
//   value      W-bit fixed-point input
//   busy       high while the string is being emitted
//   out_valid  out_data holds a valid byte
//   out_ready  consumer accepts when out_valid && out_ready
//   out_data   ASCII byte
//   out_last   marks the final byte of the string
//   ovf        integer part exceeded 9 (sticky until next accepted start)
//   done       one-cycle pulse after the last byte is accepted
module fix2dec_ascii #(
   parameter int unsigned W        = 400,
   parameter int unsigned INT_BITS = 8,
   parameter int unsigned NDIGITS  = 100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] value,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         out_last,
   output logic         ovf,
   output logic         done
);

   localparam int unsigned F = W - INT_BITS;
   localparam logic [7:0] LastCnt = 8'(NDIGITS - 1);
   localparam logic [7:0] PenCnt  = 8'(NDIGITS - 2);

`ifdef FIX2DEC_CRLF_EN
   typedef enum logic [2:0] {StIdle, StInt, StPoint, StFrac, StCr, StLf, StFin} state_e;
   localparam bit DigitLast = 1'b0;
`else
   typedef enum logic [2:0] {StIdle, StInt, StPoint, StFrac, StFin} state_e;
   localparam bit DigitLast = 1'b1;
`endif

   state_e              state_q, state_d;
   logic [INT_BITS-1:0] int_q, int_d;
   logic [F-1:0]        frac_q, frac_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          data_q, data_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   // x*10 as (x<<3)+(x<<1), widened by 4 bits so the digit lands in the top nibble
   function automatic logic [F+3:0] mul10(input logic [F-1:0] x);
      logic [F+3:0] xe;
      xe = {4'b0000, x};
      return (xe << 3) + (xe << 1);
   endfunction

   logic                hs;
   logic [F+3:0]        p_cur;
   logic [F-1:0]        frac_nx;
   logic [3:0]          dig_cur;
   logic [3:0]          dig_nx;
   logic [INT_BITS-1:0] val_int;
   logic                val_ovf;

   assign hs      = valid_q & out_ready;
   assign p_cur   = mul10(frac_q);
   assign frac_nx = p_cur[F-1:0];
   assign dig_cur = p_cur[F+3:F];
   // Digit following the one currently shown; lets out_data stay registered
   assign dig_nx  = 4'(mul10(frac_nx) >> F);
   assign val_int = value[W-1:F];
   assign val_ovf = val_int > INT_BITS'(9);

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      frac_d  = frac_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      done_d  = done_q;
      unique case (state_q)
         StIdle: begin
            done_d = 1'b0;
            if (start) begin
               int_d   = val_int;
               frac_d  = value[F-1:0];
               cnt_d   = 8'd0;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               last_d  = 1'b0;
               ovf_d   = val_ovf;
               data_d  = val_ovf ? 8'h3F : {4'h3, val_int[3:0]};
               state_d = StInt;
            end
         end
         StInt: begin
            if (hs) begin
               data_d  = 8'h2E;
               state_d = StPoint;
            end
         end
         StPoint: begin
            if (hs) begin
               data_d  = {4'h3, dig_cur};
               last_d  = DigitLast && (NDIGITS == 1);
               state_d = StFrac;
            end
         end
         StFrac: begin
            if (hs) begin
               frac_d = frac_nx;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == LastCnt) begin
`ifdef FIX2DEC_CRLF_EN
                  data_d  = 8'h0D;
                  last_d  = 1'b0;
                  state_d = StCr;
`else
                  data_d  = 8'h00;
                  last_d  = 1'b0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StFin;
`endif
               end else begin
                  data_d = {4'h3, dig_nx};
                  last_d = DigitLast && (cnt_q == PenCnt);
               end
            end
         end
`ifdef FIX2DEC_CRLF_EN
         StCr: begin
            if (hs) begin
               data_d  = 8'h0A;
               last_d  = 1'b1;
               state_d = StLf;
            end
         end
         StLf: begin
            if (hs) begin
               data_d  = 8'h00;
               last_d  = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StFin;
            end
         end
`endif
         StFin: begin
            done_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         int_q   <= '0;
         frac_q  <= '0;
         cnt_q   <= 8'd0;
         data_q  <= 8'd0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
         frac_q  <= frac_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign ovf       = ovf_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fix2dec_ascii.sv
// Self-checking bench for fix2dec_ascii. Expected strings come from a
// decimal model: digit k = floor(frac * 10^k / 2^F) mod 10.
module tb_fix2dec_ascii;

   localparam int unsigned W = 400;
   localparam int unsigned IB = 8;
   localparam int unsigned F = W - IB;
   localparam int unsigned N = 12;
`ifdef FIX2DEC_CRLF_EN
   localparam int unsigned Extra = 2;
`else
   localparam int unsigned Extra = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] value;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         out_last;
   logic         ovf;
   logic         done;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  exp_q[$];
   logic        last_ovf = 1'b0;

   fix2dec_ascii #(.W(W), .INT_BITS(IB), .NDIGITS(N)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .ovf(ovf), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_value(input logic [IB-1:0] ip);
      logic [W-1:0] v = '0;
      for (int i = 0; i < 13; i++) v = {v[W-33:0], 32'($urandom)};
      v[W-1:F] = ip;
      return v;
   endfunction

   task automatic build(input logic [W-1:0] v);
      logic [511:0] pw;
      logic [511:0] x;
      logic [511:0] d;
      logic [IB-1:0] ip;
      exp_q.delete();
      ip = v[W-1:F];
      exp_q.push_back((ip <= 9) ? (8'h30 + 8'(ip)) : 8'h3F);
      exp_q.push_back(8'h2E);
      pw = 512'd1;
      for (int k = 1; k <= int'(N); k++) begin
         pw = pw * 10;
         x  = {{(512 - F){1'b0}}, v[F-1:0]} * pw;
         d  = (x >> F) % 10;
         exp_q.push_back(8'h30 + 8'(d));
      end
`ifdef FIX2DEC_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
   endtask

   task automatic run(input logic [W-1:0] v, input int unsigned pct, input bit chk_lat);
      int unsigned cyc;
      int unsigned idx;
      int unsigned len;
      bit          got_done;
      bit          prev_stall;
      bit          exp_ovf;
      logic [7:0]  prev_data;
      logic        prev_last;
      build(v);
      len     = exp_q.size();
      exp_ovf = (v[W-1:F] > 9);
      @(posedge clk); #1;
      value = v; start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      check("idle_done_low", done, 0);
      check("idle_busy_low", busy, 0);
      check("ovf_sticky", ovf, last_ovf);
      @(posedge clk); #1;
      start = 1'b0; cyc = 1; idx = 0; got_done = 0; prev_stall = 0;
      prev_data = 8'h00; prev_last = 1'b0;
      for (int c = 0; c < int'(4 * len + 50) && !got_done; c++) begin
         value     = rnd_value(8'($urandom_range(255)));
         start     = (c == 3);
         out_ready = ($urandom_range(99) < pct);
         @(negedge clk);
         if (done) begin
            got_done = 1;
            check("fin_valid_low", out_valid, 0);
            check("fin_busy_low", busy, 0);
            check("fin_ovf", ovf, exp_ovf);
            if (chk_lat) check("latency", cyc, N + 3 + Extra);
         end else begin
            check("valid_high", out_valid, 1);
            check("busy_high", busy, 1);
            check("ovf_run", ovf, exp_ovf);
            if (idx < len) begin
               check("byte", out_data, exp_q[idx]);
               check("last", out_last, (idx == len - 1));
            end else begin
               check("extra_byte", idx, len - 1);
            end
            if (prev_stall) begin
               check("stall_data", out_data, prev_data);
               check("stall_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) idx++;
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      check("done_seen", got_done, 1);
      check("byte_count", idx, len);
      last_ovf = exp_ovf;
   endtask

   initial begin
      logic [W-1:0] v;
      rst = 1'b1; start = 1'b0; value = '0; out_ready = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_ovf", ovf, 0);
      check("rst_done", done, 0);
      #12 rst = 1'b0;

      // 1.0
      v = '0; v[W-1:F] = 8'd1;
      run(v, 100, 1'b1);
      // 0.5
      v = '0; v[F-1] = 1'b1;
      run(v, 100, 1'b1);
      // 0.1 rounded down to F bits
      v = '0; v[F] = 1'b1; v = v / 10;
      run(v, 100, 1'b0);
      // all-ones fraction: all nines, no carry into the integer
      v = '0; v[W-1:F] = 8'd3; v[F-1:0] = '1;
      run(v, 100, 1'b0);
      // integer overflow, then the next start clears ovf
      run(rnd_value(8'd12), 100, 1'b1);
      run(rnd_value(8'd7), 100, 1'b0);
      // same value with and without backpressure
      v = rnd_value(8'd2);
      run(v, 100, 1'b1);
      run(v, 30, 1'b0);
      for (int i = 0; i < 3; i++) run(rnd_value(8'($urandom_range(9))), 30, 1'b0);
      run(rnd_value(8'd200), 30, 1'b0);

      // reset mid fraction, then a fresh full string
      @(posedge clk); #1;
      value = rnd_value(8'd5); start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_last", out_last, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_ovf = 1'b0;
      run(rnd_value(8'd9), 100, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
